// File: rtl/demux_pkg.sv
// Shared types and helpers for the FIFO demux router.
// Latency: none (declarations only).
// Backpressure: n/a.
package demux_pkg;

  localparam int NUM_LANES     = 4;
  localparam int DEST_BITS     = 2;
  localparam int MAX_WORD_BITS = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Destination lane of a word: its DEST_BITS most significant bits.
  function automatic logic [DEST_BITS-1:0] dest_of(input logic [MAX_WORD_BITS-1:0] word,
                                                   input int unsigned word_bits);
    return DEST_BITS'(word >> (word_bits - DEST_BITS));
  endfunction

endpackage

// File: rtl/lane_counter.sv
// Per-lane delivered-word counter, wraps modulo 2^COUNT_BITS.
// Latency: count reflects an inc/clear one cycle after it is sampled.
// Backpressure: none; clear wins over inc in the same cycle.
module lane_counter #(
  parameter int COUNT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clear,
  output logic [COUNT_BITS-1:0] count
);

  // Wrap counter with synchronous clear taking priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_demux_router.sv
// Drains the source FIFO and routes each word to one of four lanes by its 2 MSBs; DEMUX_COUNTERS_EN adds per-lane counters.
// Latency: data_out/valid_out one cycle after the read strobe is sampled.
// Backpressure: any lane pause stalls all reads; one word already in flight is still delivered.
module fifo_demux_router #(
  parameter int DATA_BITS  = 10,
  parameter int NUM_LANES  = 4,
  parameter int COUNT_BITS = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          fifo_data_out,
  input  logic                          fifo_empty_out,
  output logic                          fifo_read,
  input  logic [NUM_LANES-1:0]          pause,
  output logic [DATA_BITS-1:0]          data_out,
  output logic [NUM_LANES-1:0]          valid_out,
  output logic                          idle,
  input  logic                          count_clear,
  output logic [NUM_LANES*COUNT_BITS-1:0] count_out
);

  import demux_pkg::*;

  state_t               state;
  logic                 in_flight;
  logic [DEST_BITS-1:0] dest;

  assign dest = dest_of(MAX_WORD_BITS'(fifo_data_out), DATA_BITS);

  // The destination is unknown until the word arrives, so any pause blocks the read.
  assign fifo_read = (state == ACTIVE) & ~fifo_empty_out & (pause == '0);
  assign idle      = (state == IDLE) & ~in_flight;

  // Control FSM: wake on data, go back to sleep once drained and nothing is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty_out) state <= ACTIVE;
        ACTIVE:  if (fifo_empty_out && !in_flight) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: capture the word returned for last cycle's read and strobe its lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= 1'b0;
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      in_flight <= fifo_read;
      if (in_flight) begin
        data_out  <= fifo_data_out;
        valid_out <= NUM_LANES'(1) << dest;
      end else begin
        valid_out <= '0;
      end
    end
  end

`ifdef DEMUX_COUNTERS_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_counter #(
      .COUNT_BITS(COUNT_BITS)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (in_flight && (dest == DEST_BITS'(i))),
      .clear (count_clear),
      .count (count_out[i*COUNT_BITS +: COUNT_BITS])
    );
  end
`else
  logic unused_count_clear;
  assign unused_count_clear = count_clear;
  assign count_out          = '0;
`endif

endmodule

// File: tb/tb_fifo_demux_router.sv
module tb_fifo_demux_router;

  localparam int DW = 10;
  localparam int NL = 4;
  localparam int CB = 5;
`ifdef DEMUX_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     fifo_data_out;
  logic              fifo_empty_out;
  logic              fifo_read;
  logic [NL-1:0]     pause;
  logic [DW-1:0]     data_out;
  logic [NL-1:0]     valid_out;
  logic              idle;
  logic              count_clear;
  logic [NL*CB-1:0]  count_out;

  always #5 clk = ~clk;

  fifo_demux_router #(.DATA_BITS(DW), .NUM_LANES(NL), .COUNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .fifo_data_out(fifo_data_out), .fifo_empty_out(fifo_empty_out),
    .fifo_read(fifo_read), .pause(pause), .data_out(data_out), .valid_out(valid_out),
    .idle(idle), .count_clear(count_clear), .count_out(count_out)
  );

  int tests = 0;
  int fails = 0;

  // Source FIFO model and expected-output model.
  logic [DW-1:0] src_q[$];
  logic          rd_s;
  bit            have_flight;
  logic [DW-1:0] flight_word;
  logic [NL-1:0] exp_valid;
  logic [DW-1:0] exp_data;
  int            exp_cnt[NL];
  int            read_cnt, deliv_cnt, stall_run;

  // Values seen at the most recent negedge.
  logic [NL-1:0]    last_vo;
  logic [DW-1:0]    last_do;
  logic [NL*CB-1:0] last_co;
  logic             last_idle, last_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NL*CB-1:0] exp_count_vec();
    logic [NL*CB-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) v[i*CB +: CB] = CB'(exp_cnt[i]);
    return v;
  endfunction

  task automatic model_clear();
    src_q.delete();
    have_flight    = 1'b0;
    exp_valid      = '0;
    exp_data       = '0;
    for (int i = 0; i < NL; i++) exp_cnt[i] = 0;
    fifo_empty_out = 1'b1;
    fifo_data_out  = '0;
  endtask

  // One clock: compare at negedge, then advance the model just after the rising edge.
  task automatic step();
    int lane;
    @(negedge clk);
    rd_s      = fifo_read;
    last_vo   = valid_out;
    last_do   = data_out;
    last_co   = count_out;
    last_idle = idle;
    last_rd   = fifo_read;
    chk("valid_out", valid_out, exp_valid);
    chk("data_out", data_out, exp_data);
    chk("count_out", count_out, exp_count_vec());
    chk("read_legal", fifo_read & (fifo_empty_out | (|pause) | ~reset), 0);
    if (reset && !fifo_empty_out && pause == '0 && !fifo_read) stall_run++;
    else stall_run = 0;
    chk("no_stall", stall_run > 1, 0);
    @(posedge clk);
    #1;
    if (!reset) begin
      model_clear();
    end else begin
      if (have_flight) begin
        lane      = int'(flight_word[DW-1 -: 2]);
        exp_valid = 4'b0001 << lane;
        exp_data  = flight_word;
        deliv_cnt++;
      end else begin
        exp_valid = '0;
      end
      if (CNT_EN) begin
        if (count_clear) begin
          for (int i = 0; i < NL; i++) exp_cnt[i] = 0;
        end else if (have_flight) begin
          exp_cnt[lane] = (exp_cnt[lane] + 1) % (1 << CB);
        end
      end
      have_flight = 1'b0;
      if (rd_s) begin
        read_cnt++;
        chk("over_read", src_q.size() == 0, 0);
        if (src_q.size() > 0) begin
          flight_word   = src_q.pop_front();
          fifo_data_out = flight_word;
          have_flight   = 1'b1;
        end
      end
      fifo_empty_out = (src_q.size() == 0);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((src_q.size() > 0 || have_flight) && n < 300) begin step(); n++; end
    chk(name, n >= 300, 0);
    repeat (3) step();
  endtask

  logic [DW-1:0] route_words[4];
  int r0, d0, n, pulses, npush;
  logic [NL-1:0] seen_vo;

  initial begin
    route_words[0] = 10'h0A5; route_words[1] = 10'h1FF;
    route_words[2] = 10'h2AA; route_words[3] = 10'h3C5;
    reset = 1'b0; pause = '0; count_clear = 1'b0;
    read_cnt = 0; deliv_cnt = 0; stall_run = 0; flight_word = '0;
    model_clear();

    // Reset held low for 8 cycles.
    repeat (8) step();
    chk("rst_fifo_read", last_rd, 0);
    chk("rst_valid_out", last_vo, 0);
    chk("rst_data_out", last_do, 0);
    chk("rst_idle", last_idle, 1);
    chk("rst_count_out", last_co, 0);
    reset = 1'b1;
    repeat (3) step();
    chk("release_idle", last_idle, 1);

    // Routing by MSBs with fixed latency.
    for (int i = 0; i < 4; i++) src_q.push_back(route_words[i]);
    step();
    step(); chk("route_no_read_idle", last_rd, 0);
    step(); chk("route_first_read", last_rd, 1);
    step(); chk("route_pre_valid", last_vo, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("route_valid", last_vo, 4'b0001 << k);
      chk("route_data", last_do, route_words[k]);
    end
    step(); chk("route_post_valid", last_vo, 0);
    drain("route_drain_timeout");
    chk("route_idle", last_idle, 1);

    // Single word at the empty boundary.
    r0 = read_cnt; pulses = 0; seen_vo = '0;
    src_q.push_back(10'h155);
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_vo != '0) begin pulses++; seen_vo = last_vo; end
    end
    chk("single_reads", read_cnt - r0, 1);
    chk("single_pulses", pulses, 1);
    chk("single_lane", seen_vo, 4'b0010);
    chk("single_idle", last_idle, 1);

    // Pause after the second read.
    r0 = read_cnt; d0 = deliv_cnt;
    for (int i = 0; i < 6; i++) src_q.push_back({2'(i), 8'h30 + 8'(i)});
    n = 0;
    while (read_cnt - r0 < 2 && n < 50) begin step(); n++; end
    chk("pause_wait_timeout", n >= 50, 0);
    pause = 4'b0100;
    repeat (5) step();
    chk("pause_reads", read_cnt - r0, 2);
    chk("pause_deliv", deliv_cnt - d0, 2);
    pause = '0;
    drain("pause_drain_timeout");
    chk("pause_total_deliv", deliv_cnt - d0, 6);
    chk("pause_total_reads", read_cnt - r0, 6);

    // Counter wrap on lane 3, then clear against a simultaneous increment.
    count_clear = 1'b1; step(); count_clear = 1'b0;
    d0 = deliv_cnt;
    for (int i = 0; i < 33; i++) src_q.push_back({2'b11, 8'(i)});
    n = 0;
    while (deliv_cnt - d0 < 33 && n < 200) begin step(); n++; end
    chk("wrap_timeout", n >= 200, 0);
    step();
    chk("wrap_count", last_co, CNT_EN ? (20'h1 << 15) : 20'h0);
    drain("wrap_drain_timeout");
    r0 = read_cnt;
    src_q.push_back(10'h3EE);
    n = 0;
    while (read_cnt == r0 && n < 20) begin step(); n++; end
    chk("clear_wait_timeout", n >= 20, 0);
    count_clear = 1'b1; step(); count_clear = 1'b0;
    step();
    chk("clear_valid", last_vo, 4'b1000);
    chk("clear_prio", last_co, 0);
    drain("clear_drain_timeout");

    // Reset asserted while a word is in flight.
    for (int i = 0; i < 8; i++) src_q.push_back(10'($urandom));
    n = 0;
    while (!have_flight && n < 20) begin step(); n++; end
    chk("rstmid_wait_timeout", n >= 20, 0);
    reset = 1'b0;
    #1;
    chk("rstmid_valid", valid_out, 0);
    chk("rstmid_data", data_out, 0);
    chk("rstmid_idle", idle, 1);
    chk("rstmid_read", fifo_read, 0);
    model_clear();
    d0 = deliv_cnt;
    repeat (3) step();
    chk("rstmid_no_deliv", deliv_cnt - d0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) src_q.push_back(10'($urandom));
    drain("rstmid_drain_timeout");
    chk("rstmid_restart_deliv", deliv_cnt - d0, 3);

    // Randomized traffic with random pause and clears.
    d0 = deliv_cnt; npush = 0;
    for (int c = 0; c < 1500; c++) begin
      if (src_q.size() < 12) begin
        int k;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin src_q.push_back(10'($urandom)); npush++; end
      end
      pause       = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      count_clear = ($urandom_range(0, 19) == 0);
      step();
    end
    pause = '0; count_clear = 1'b0;
    drain("rand_drain_timeout");
    chk("rand_all_delivered", deliv_cnt - d0, npush);
    chk("rand_idle", last_idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
